// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_WORD_W = 32;
    localparam int BYTE_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERROR
    } state_t;

    function automatic logic [BYTE_W-1:0] imem_checksum(
        input logic [BYTE_W-1:0] acc,
        input logic [BYTE_W-1:0] data
    );
        return acc ^ data;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles four accepted bytes, least-significant first, into one 32-bit word.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   accept,
    input  logic [BYTE_W-1:0]      data_byte,
    input  logic                   clear,
    output logic [IMEM_WORD_W-1:0] word,
    output logic                   word_complete
);

    logic [1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (accept) begin
            word[BYTE_W*int'(idx) +: BYTE_W] <= data_byte;
            idx                              <= idx + 2'd1;
        end
    end

    assign word_complete = accept && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory; holds the core in
// reset until a frame has been written and its checksum verified.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          DEPTH     = IMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_STEP = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [BYTE_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [IMEM_WORD_W-1:0] mem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   cpu_hold,
    output logic [6:0]             words_written
);

    state_t            state, state_next;
    logic [BYTE_W-1:0] n_words;
    logic [BYTE_W-1:0] checksum;
    logic              accept;
    logic              word_complete;
    logic              last_word;
    logic              count_bad;

    assign accept    = in_valid && in_ready;
    assign last_word = ({1'b0, words_written} + 8'd1) == n_words;
    assign count_bad = (in_data == '0) || (int'(in_data) > DEPTH);

    imem_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .accept       (accept && (state == DATA)),
        .data_byte    (in_data),
        .clear        (state == WRITE),
        .word         (mem_wdata),
        .word_complete(word_complete)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state)
            IDLE: if (start) state_next = HDR;
            HDR: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_next = count_bad ? ERROR : DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (word_complete) state_next = WRITE;
            end
            WRITE: begin
                // Gated by rst so a strobe cannot escape on the reset cycle.
                mem_we     = !rst;
                busy       = 1'b1;
                state_next = last_word ? CHK : DATA;
            end
            CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_next = (in_data == checksum) ? DONE : ERROR;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = HDR;
            end
            ERROR: begin
                error = 1'b1;
                if (start) state_next = HDR;
            end
            default: state_next = IDLE;
        endcase
        cpu_hold = !done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr      <= BASE_ADDR;
            words_written <= '0;
            checksum      <= '0;
            n_words       <= '0;
        end else begin
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        mem_addr      <= BASE_ADDR;
                        words_written <= '0;
                        checksum      <= '0;
                    end
                end
                HDR:   if (accept && !count_bad) n_words <= in_data;
                DATA:  if (accept) checksum <= imem_checksum(checksum, in_data);
                WRITE: begin
                    words_written <= words_written + 7'd1;
                    if (!last_word) mem_addr <= mem_addr + 32'(ADDR_STEP);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader with a strobe logger.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, busy, done, error, cpu_hold;
    logic [31:0] mem_addr, mem_wdata;
    logic [6:0]  words_written;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] st_addr[$];
    logic [31:0] st_data[$];
    int          st_cyc[$];
    int          acc_q[$];

    imem_loader #(
        .DEPTH    (64),
        .BASE_ADDR(32'h0000_0000),
        .ADDR_STEP(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .cpu_hold     (cpu_hold),
        .words_written(words_written)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            st_addr.push_back(mem_addr);
            st_data.push_back(mem_wdata);
            st_cyc.push_back(cyc);
            check("ready_low_in_write", 32'(in_ready), 32'd0);
        end
    end

    typedef struct {
        logic [7:0]        n;
        logic [2:0][31:0]  w;
        logic [7:0]        csum;
        bit                gap;
        bit                exp_done;
        int                exp_writes;
    } vec_t;

    vec_t vecs[6];

    task automatic clear_log();
        st_addr.delete(); st_data.delete(); st_cyc.delete(); acc_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, output int acc);
        int t;
        t = 0;
        acc = -1;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL byte_accept_timeout: got in_ready=%b expected 1", in_ready);
        end else begin
            acc = cyc;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        @(negedge clk);
        while (done !== 1'b1 && error !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (done !== 1'b1 && error !== 1'b1) begin
            tests++; fails++;
            $display("FAIL end_timeout: got done=%b error=%b expected one set", done, error);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_words"}, 32'(words_written), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          acc;
        logic [31:0] wd;
        string       tag;
        tag = $sformatf("v%0d", id);
        clear_log();
        pulse_start();
        send_byte(v.n, v.gap, acc);
        for (int i = 0; i < v.exp_writes; i++) begin
            wd = v.w[i];
            for (int b = 0; b < 4; b++) begin
                send_byte(wd[8*b +: 8], v.gap, acc);
                if (b == 3) acc_q.push_back(acc);
            end
        end
        if (v.exp_writes > 0) send_byte(v.csum, v.gap, acc);
        wait_end();
        check({tag, "_done"}, 32'(done), 32'(v.exp_done));
        check({tag, "_error"}, 32'(error), 32'(!v.exp_done));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!v.exp_done));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_words"}, 32'(words_written), 32'(v.exp_writes));
        check({tag, "_strobes"}, 32'(st_addr.size()), 32'(v.exp_writes));
        for (int i = 0; i < v.exp_writes && i < st_addr.size(); i++) begin
            check({tag, $sformatf("_addr%0d", i)}, st_addr[i], 32'(4 * i));
            check({tag, $sformatf("_data%0d", i)}, st_data[i], v.w[i]);
            check({tag, $sformatf("_lat%0d", i)}, 32'(st_cyc[i]), 32'(acc_q[i] + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        logic [31:0] wd;
        logic [7:0]  cs;
        logic [31:0] exp_w[$];

        //            n       words {w2,w1,w0}                                csum   gap  done writes
        vecs[0] = '{8'd1,  {32'h0, 32'h0, 32'h00A50513},                  8'hB3, 1'b0, 1'b1, 1};
        vecs[1] = '{8'd3,  {32'h99AABBCC, 32'h55667788, 32'h11223344},     8'hCC, 1'b1, 1'b1, 3};
        vecs[2] = '{8'd0,  {32'h0, 32'h0, 32'h0},                          8'h00, 1'b0, 1'b0, 0};
        vecs[3] = '{8'd65, {32'h0, 32'h0, 32'h0},                          8'h00, 1'b0, 1'b0, 0};
        vecs[4] = '{8'd2,  {32'h0, 32'h12345678, 32'hDEADBEEF},            8'h2B, 1'b0, 1'b0, 2};
        vecs[5] = '{8'd1,  {32'h0, 32'h0, 32'h00000013},                   8'h13, 1'b0, 1'b1, 1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

        // Reset on the cycle the 4th byte of word 1 is accepted.
        clear_log();
        pulse_start();
        send_byte(8'd2, 1'b0, acc);
        for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(b), 1'b0, acc);
        for (int b = 0; b < 3; b++) send_byte(8'h20 + 8'(b), 1'b0, acc);
        in_valid = 1'b1;
        in_data  = 8'h23;
        rst      = 1'b1;
        @(negedge clk);
        check("rst_cycle_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        check("midrst_strobes", 32'(st_addr.size()), 32'd1);
        if (st_addr.size() > 0) check("midrst_word0", st_data[0], 32'h13121110);
        @(posedge clk); #1;

        // Full 64-word load, back to back, with a stray start in the middle.
        clear_log();
        exp_w.delete();
        cs = '0;
        pulse_start();
        send_byte(8'd64, 1'b0, acc);
        for (int i = 0; i < 64; i++) begin
            wd = {i[7:0], 8'hC3 ^ i[7:0], 8'h3C, 8'(i * 7)};
            exp_w.push_back(wd);
            cs = cs ^ wd[7:0] ^ wd[15:8] ^ wd[23:16] ^ wd[31:24];
            for (int b = 0; b < 4; b++) begin
                if (i == 10 && b == 0) start = 1'b1;
                send_byte(wd[8*b +: 8], 1'b0, acc);
                start = 1'b0;
            end
        end
        send_byte(cs, 1'b0, acc);
        wait_end();
        check("full_done", 32'(done), 32'd1);
        check("full_error", 32'(error), 32'd0);
        check("full_cpu_hold", 32'(cpu_hold), 32'd0);
        check("full_words", 32'(words_written), 32'd64);
        check("full_strobes", 32'(st_addr.size()), 32'd64);
        if (st_addr.size() == 64) begin
            check("full_last_addr", st_addr[63], 32'h0000_00FC);
            for (int i = 0; i < 64; i++) begin
                check($sformatf("full_addr%0d", i), st_addr[i], 32'(4 * i));
                check($sformatf("full_data%0d", i), st_data[i], exp_w[i]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
